// File: rtl/m_dram_arbiter.sv
// m_dram_arbiter: round-robin arbiter from NHARTS per-hart MMU DRAM ports onto one DRAM controller.
// Optional feature ARB_LOCK_EN: an LR/SC owner may keep the bus for up to LOCK_MAX cycles.
module m_dram_arbiter #(
    parameter int NHARTS   = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [NHARTS*32-1:0] w_h_addr,
    input  logic [NHARTS*32-1:0] w_h_wdata,
    input  logic [NHARTS*3-1:0]  w_h_ctrl,
    input  logic [NHARTS-1:0]    w_h_we,
    input  logic [NHARTS-1:0]    w_h_le,
    input  logic [NHARTS-1:0]    w_h_lock,
    output logic [NHARTS-1:0]    w_h_busy,
    output logic [31:0]          w_h_odata,
    output logic [31:0]          w_grant,
    output logic [31:0]          w_dram_addr,
    output logic [31:0]          w_dram_wdata,
    output logic [2:0]           w_dram_ctrl,
    output logic                 w_dram_we,
    output logic                 w_dram_le,
    input  logic                 w_dram_busy,
    input  logic [31:0]          w_dram_odata,
    output logic [2:0]           w_dbg_state
);
    localparam int OW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [NHARTS-1:0] pend_q;
    logic [NHARTS-1:0] swe_q;
    logic [31:0]       addr_q  [NHARTS];
    logic [31:0]       wdata_q [NHARTS];
    logic [2:0]        ctrl_q  [NHARTS];
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     rr_q;
    logic [1:0]        arm_cnt_q;
    logic [31:0]       odata_q;
    logic [31:0]       grant_q;
    logic [31:0]       daddr_q;
    logic [31:0]       dwdata_q;
    logic [2:0]        dctrl_q;
    logic              dwe_q;
    logic              dle_q;

    logic              sel_found;
    logic [OW-1:0]     sel_idx;
    int                sel_dist;
    int                sel_best;
    logic              iss_go;
    logic [OW-1:0]     iss_idx;

`ifdef ARB_LOCK_EN
    logic              lock_act_q;
    logic [15:0]       held_q;
    logic              lock_rel;
`else
    logic              unused_lock;
    assign unused_lock = ^w_h_lock;
`endif

    function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] p);
        if (int'(p) >= NHARTS - 1) return '0;
        return p + OW'(1);
    endfunction

    // Pick the pending hart with the smallest forward distance from rr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_best  = NHARTS;
        sel_dist  = 0;
        for (int i = 0; i < NHARTS; i++) begin
            sel_dist = i - int'(rr_q);
            if (sel_dist < 0) sel_dist = sel_dist + NHARTS;
            if (pend_q[i] && sel_dist < sel_best) begin
                sel_best  = sel_dist;
                sel_found = 1'b1;
                sel_idx   = OW'(i);
            end
        end
    end

    always_comb begin
        iss_go  = sel_found;
        iss_idx = sel_idx;
`ifdef ARB_LOCK_EN
        lock_rel = lock_act_q && (!w_h_lock[owner_q] || held_q >= 16'(LOCK_MAX));
        if (lock_act_q) begin
            iss_go  = !lock_rel && pend_q[owner_q];
            iss_idx = owner_q;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            swe_q     <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            arm_cnt_q <= '0;
            odata_q   <= '0;
            grant_q   <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dctrl_q   <= '0;
            dwe_q     <= 1'b0;
            dle_q     <= 1'b0;
            for (int i = 0; i < NHARTS; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                ctrl_q[i]  <= '0;
            end
`ifdef ARB_LOCK_EN
            lock_act_q <= 1'b0;
            held_q     <= '0;
`endif
        end else begin
            // A hart that already has a pending slot cannot overwrite it.
            for (int i = 0; i < NHARTS; i++) begin
                if ((w_h_we[i] || w_h_le[i]) && !pend_q[i]) begin
                    pend_q[i]  <= 1'b1;
                    swe_q[i]   <= w_h_we[i];
                    addr_q[i]  <= w_h_addr[32*i +: 32];
                    wdata_q[i] <= w_h_wdata[32*i +: 32];
                    ctrl_q[i]  <= w_h_ctrl[3*i +: 3];
                end
            end
`ifdef ARB_LOCK_EN
            if ((state_q != S_IDLE || lock_act_q) && held_q != '1)
                held_q <= held_q + 16'd1;
`endif
            case (state_q)
                S_IDLE: begin
`ifdef ARB_LOCK_EN
                    if (lock_rel) begin
                        lock_act_q <= 1'b0;
                        held_q     <= '0;
                        rr_q       <= next_ptr(owner_q);
                    end else
`endif
                    if (iss_go) begin
                        owner_q  <= iss_idx;
                        grant_q  <= 32'(iss_idx);
                        daddr_q  <= addr_q[iss_idx];
                        dwdata_q <= wdata_q[iss_idx];
                        dctrl_q  <= ctrl_q[iss_idx];
                        dwe_q    <= swe_q[iss_idx];
                        dle_q    <= !swe_q[iss_idx];
                        state_q  <= S_ISSUE;
`ifdef ARB_LOCK_EN
                        if (!lock_act_q) held_q <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    dwe_q     <= 1'b0;
                    dle_q     <= 1'b0;
                    arm_cnt_q <= '0;
                    state_q   <= S_ARM;
                end
                S_ARM: begin
                    // A controller that never raises busy is treated as done after 4 cycles.
                    if (w_dram_busy) state_q <= S_WAIT;
                    else if (arm_cnt_q == 2'd3) state_q <= S_DONE;
                    else arm_cnt_q <= arm_cnt_q + 2'd1;
                end
                S_WAIT: begin
                    if (!w_dram_busy) begin
                        odata_q <= w_dram_odata;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    pend_q[owner_q] <= 1'b0;
                    daddr_q         <= '0;
                    dwdata_q        <= '0;
                    dctrl_q         <= '0;
                    state_q         <= S_IDLE;
`ifdef ARB_LOCK_EN
                    if (w_h_lock[owner_q] && (held_q + 16'd1) < 16'(LOCK_MAX)) begin
                        lock_act_q <= 1'b1;
                        rr_q       <= owner_q;
                    end else begin
                        lock_act_q <= 1'b0;
                        held_q     <= '0;
                        rr_q       <= next_ptr(owner_q);
                    end
`else
                    rr_q <= next_ptr(owner_q);
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign w_h_busy     = pend_q | w_h_we | w_h_le;
    assign w_h_odata    = odata_q;
    assign w_grant      = grant_q;
    assign w_dram_addr  = daddr_q;
    assign w_dram_wdata = dwdata_q;
    assign w_dram_ctrl  = dctrl_q;
    assign w_dram_we    = dwe_q;
    assign w_dram_le    = dle_q;
    assign w_dbg_state  = state_q;
endmodule

// File: tb/tb_m_dram_arbiter.sv
// Bench for m_dram_arbiter: timestamp-level reference model of the arbiter plus a bench-driven DRAM controller.
module tb_m_dram_arbiter;
  localparam int NH = 2;
  localparam int LM = 8;

  logic              CLK;
  logic              RST_X;
  logic [NH*32-1:0]  h_addr;
  logic [NH*32-1:0]  h_wdata;
  logic [NH*3-1:0]   h_ctrl;
  logic [NH-1:0]     h_we;
  logic [NH-1:0]     h_le;
  logic [NH-1:0]     h_lock;
  logic [NH-1:0]     h_busy;
  logic [31:0]       h_odata;
  logic [31:0]       grant;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [2:0]        d_ctrl;
  logic              d_we;
  logic              d_le;
  logic              d_busy;
  logic [31:0]       d_odata;
  logic [2:0]        dbg_state;

  m_dram_arbiter #(.NHARTS(NH), .LOCK_MAX(LM)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .w_h_addr(h_addr), .w_h_wdata(h_wdata), .w_h_ctrl(h_ctrl),
    .w_h_we(h_we), .w_h_le(h_le), .w_h_lock(h_lock), .w_h_busy(h_busy),
    .w_h_odata(h_odata), .w_grant(grant),
    .w_dram_addr(d_addr), .w_dram_wdata(d_wdata), .w_dram_ctrl(d_ctrl),
    .w_dram_we(d_we), .w_dram_le(d_le), .w_dram_busy(d_busy), .w_dram_odata(d_odata),
    .w_dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model: pending slots, rr pointer and the timeline of the current transaction
  logic [NH-1:0] mpend;
  logic [31:0]   maddr [NH];
  logic [31:0]   mwdata [NH];
  logic [2:0]    mctrl [NH];
  logic [NH-1:0] mwe;
  int            mrr, mown;
  bit            midle, m_to;
  int            t_issue, t_blo, t_bhi, t_done;
  logic [31:0]   exp_odata, exp_grant;
  logic [31:0]   exp_q[$];
  bit            done_chk;

  bit            force_cfg, f_to, force_od, dir_addr_en, last_wait, h1_track;
  int            f_a, f_b, h1_wait;
  logic [31:0]   od_val, dir_addr;
  logic [31:0]   strobe_grant[$];
  logic [31:0]   lock_seq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    mpend = '0; mwe = '0; mrr = 0; mown = 0; midle = 1'b1; m_to = 1'b0;
    t_issue = -10; t_blo = -10; t_bhi = -10; t_done = -10;
    exp_odata = '0; exp_grant = '0; exp_q.delete(); done_chk = 1'b0;
    last_wait = 1'b0; h1_track = 1'b0;
    for (int i = 0; i < NH; i++) begin
      maddr[i] = '0; mwdata[i] = '0; mctrl[i] = '0;
    end
  endtask

  // driver: one clock cycle with the given request pulses, then score and advance the model
  task automatic run_cycle(input logic [NH-1:0] rwe, input logic [NH-1:0] rle);
    logic [NH-1:0] old;
    logic [NH-1:0] req;
    int a, b;
    bit found;
    @(posedge CLK); #1;
    d_busy  = !midle && !m_to && cyc >= t_blo && cyc <= t_bhi;
    d_odata = force_od ? od_val : $urandom();
    h_we = rwe;
    h_le = rle;
`ifndef ARB_LOCK_EN
    h_lock = NH'($urandom());
`endif
    for (int i = 0; i < NH; i++) begin
      if (rwe[i] || rle[i]) begin
        h_addr[32*i +: 32]  = $urandom();
        h_wdata[32*i +: 32] = $urandom();
        h_ctrl[3*i +: 3]    = 3'($urandom_range(0, 7));
        if (dir_addr_en && i == 0) h_addr[31:0] = dir_addr;
      end
    end
    #1;
    req = rwe | rle;
    check("busy", 32'(h_busy), 32'(mpend | req));
    check("dram_we", 32'(d_we), 32'(!midle && cyc == t_issue && mwe[mown]));
    check("dram_le", 32'(d_le), 32'(!midle && cyc == t_issue && !mwe[mown]));
    check("dram_addr", d_addr, midle ? 32'h0 : maddr[mown]);
    check("dram_wdata", d_wdata, midle ? 32'h0 : mwdata[mown]);
    check("dram_ctrl", 32'(d_ctrl), midle ? 32'h0 : 32'(mctrl[mown]));
    check("grant", grant, exp_grant);
    check("odata", h_odata, exp_odata);
    if (done_chk && exp_q.size() > 0) check("read_data", h_odata, exp_q.pop_front());
    done_chk = 1'b0;
    if (d_we || d_le) begin
      strobe_grant.push_back(grant);
      if (h1_track) begin
        if (grant == 32'd1) begin
          check("fair_h1", 32'(h1_wait <= 1), 32'd1);
          h1_track = 1'b0;
        end else h1_wait++;
      end
    end
    // model: what the next edge does
    old = mpend;
    last_wait = !midle && !m_to && cyc > t_blo && cyc < t_done;
    if (midle) begin
      if (old != '0) begin
        found = 1'b0;
        for (int k = 0; k < NH; k++) begin
          if (!found && old[(mrr + k) % NH]) begin
            found = 1'b1;
            mown  = (mrr + k) % NH;
          end
        end
        midle     = 1'b0;
        exp_grant = 32'(mown);
        t_issue   = cyc + 1;
        if (force_cfg) begin
          m_to = f_to; a = f_a; b = f_b;
        end else begin
          m_to = ($urandom_range(0, 4) == 0);
          a    = $urandom_range(0, 3);
          b    = $urandom_range(1, 4);
        end
        t_blo  = t_issue + 1 + a;
        t_bhi  = t_issue + a + b;
        t_done = m_to ? t_issue + 5 : t_issue + 2 + a + b;
      end
    end else begin
      if (!m_to && cyc == t_done - 1) begin
        exp_odata = d_odata;
        exp_q.push_back(d_odata);
      end
      if (cyc == t_done) begin
        mpend[mown] = 1'b0;
        mrr         = (mown + 1) % NH;
        midle       = 1'b1;
        done_chk    = 1'b1;
      end
    end
    for (int i = 0; i < NH; i++) begin
      if (req[i] && !old[i]) begin
        mpend[i]  = 1'b1;
        mwe[i]    = rwe[i];
        maddr[i]  = h_addr[32*i +: 32];
        mwdata[i] = h_wdata[32*i +: 32];
        mctrl[i]  = h_ctrl[3*i +: 3];
      end
    end
    cyc++;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((!midle || mpend != '0) && k < limit) begin
      run_cycle('0, '0);
      k++;
    end
    run_cycle('0, '0);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    h_we = '0; h_le = '0; h_lock = '0; d_busy = 1'b0; d_odata = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
  endtask

  initial begin
    h_addr = '0; h_wdata = '0; h_ctrl = '0;
    force_cfg = 1'b0; force_od = 1'b0; dir_addr_en = 1'b0;
    f_to = 1'b0; f_a = 0; f_b = 1; od_val = '0; dir_addr = '0; h1_wait = 0;
    RST_X = 1'b0;
    h_we = '0; h_le = '0; h_lock = '0; d_busy = 1'b0; d_odata = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(h_busy), 32'h0);
    check("rst_we", 32'(d_we), 32'h0);
    check("rst_le", 32'(d_le), 32'h0);
    check("rst_grant", grant, 32'h0);
    check("rst_odata", h_odata, 32'h0);
    check("rst_addr", d_addr, 32'h0);
    @(negedge CLK);
    RST_X = 1'b1;

    // simultaneous writes from both harts with rr at 0
    strobe_grant.delete();
    run_cycle(2'b11, 2'b00);
    drain(60);
    check("simul_count", 32'(strobe_grant.size()), 32'd2);
    for (int i = 0; i < strobe_grant.size() && i < 2; i++)
      check("simul_order", strobe_grant[i], 32'(i));

    // single read by hart0, controller busy for 3 cycles
    strobe_grant.delete();
    force_cfg = 1'b1; f_to = 1'b0; f_a = 0; f_b = 3;
    force_od = 1'b1; od_val = 32'hDEADBEEF;
    dir_addr_en = 1'b1; dir_addr = 32'h80000010;
    run_cycle(2'b00, 2'b01);
    drain(40);
    dir_addr_en = 1'b0; force_od = 1'b0;
    check("read_count", 32'(strobe_grant.size()), 32'd1);
    check("read_odata", h_odata, 32'hDEADBEEF);
    check("read_grant", grant, 32'd0);

    // controller that never raises busy
    f_to = 1'b1;
    run_cycle(2'b00, 2'b10);
    drain(40);
    run_cycle(2'b01, 2'b00);
    drain(40);
    force_cfg = 1'b0;

    // fairness: hart0 re-requests whenever idle, hart1 requests once
    for (int k = 0; k < 60; k++) begin
      logic [NH-1:0] w;
      w = '0;
      w[0] = !mpend[0];
      if (k == 3) begin
        w[1] = 1'b1;
        h1_track = 1'b1;
        h1_wait = 0;
      end
      run_cycle(w, '0);
    end
    drain(60);
    check("fair_served", 32'(h1_track), 32'd0);

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      logic [NH-1:0] w, l;
      w = '0; l = '0;
      for (int i = 0; i < NH; i++) begin
        if (!mpend[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) w[i] = 1'b1;
          else l[i] = 1'b1;
        end
      end
      run_cycle(w, l);
    end
    drain(80);

    // reset while the controller is still busy
    force_cfg = 1'b1; f_to = 1'b0; f_a = 0; f_b = 4;
    run_cycle(2'b00, 2'b01);
    begin
      int k;
      k = 0;
      while (!last_wait && k < 20) begin
        run_cycle('0, '0);
        k++;
      end
      check("reached_wait", 32'(last_wait), 32'd1);
    end
    force_cfg = 1'b0;
    RST_X = 1'b0;
    h_we = '0; h_le = '0; d_busy = 1'b0;
    #1;
    check("arst_we", 32'(d_we), 32'h0);
    check("arst_le", 32'(d_le), 32'h0);
    check("arst_grant", grant, 32'h0);
    check("arst_busy", 32'(h_busy), 32'h0);
    check("arst_addr", d_addr, 32'h0);
    model_reset();
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    run_cycle(2'b00, 2'b10);
    drain(40);
    check("post_rst_grant", grant, 32'd1);
    check("post_rst_busy", 32'(h_busy), 32'h0);

`ifdef ARB_LOCK_EN
    // locked hart0 keeps the bus until LOCK_MAX forces a release
    do_reset();
    h_lock = 2'b01;
    lock_seq.delete();
    for (int k = 0; k < 300 && lock_seq.size() < 3; k++) begin
      @(posedge CLK); #1;
      h_we = '0; h_le = '0; d_busy = 1'b0;
      if (!h_busy[0]) h_we[0] = 1'b1;
      if (k == 0) h_le[1] = 1'b1;
      #1;
      if (d_we || d_le) lock_seq.push_back(grant);
    end
    check("lock_count", 32'(lock_seq.size()), 32'd3);
    begin
      logic [31:0] lexp [3];
      lexp[0] = 32'd0; lexp[1] = 32'd0; lexp[2] = 32'd1;
      for (int i = 0; i < lock_seq.size() && i < 3; i++) check("lock_order", lock_seq[i], lexp[i]);
    end
    h_lock = '0;
`endif

    // report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
